// File: rtl/cdb_arbiter.sv
// cdb_arbiter: drains per-source result FIFOs (ALU, LSB) round-robin onto a registered CDB.
// Optional build macro CDB_BYPASS_EN: an empty source that wins arbitration skips its FIFO.

module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
endmodule

module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ENTRY_W    = 6
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               alu_valid_in,
  input  logic [ENTRY_W-1:0] alu_entry_in,
  input  logic [31:0]        alu_value_in,
  input  logic [31:0]        alu_pc_in,
  output logic               alu_ready_out,
  input  logic               lsb_valid_in,
  input  logic [ENTRY_W-1:0] lsb_entry_in,
  input  logic [31:0]        lsb_value_in,
  output logic               lsb_ready_out,
  output logic               cdb_valid_out,
  output logic               cdb_src_out,
  output logic [ENTRY_W-1:0] cdb_entry_out,
  output logic [31:0]        cdb_value_out,
  output logic [31:0]        cdb_pc_out
);
  localparam int NUM_SRC = 2;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [ENTRY_W-1:0] entry;
    logic [31:0]        value;
    logic [31:0]        pc;
  } res_t;

  res_t [NUM_SRC-1:0]          in_res, head_res, sel_res;
  logic [NUM_SRC-1:0]          req, ready, push, fifo_push, fifo_pop, nonempty, cand;
  logic [NUM_SRC-1:0][CW-1:0]  count;
  logic                        active, last_grant, gnt_vld, gnt_src;

  // roll-back wins over pause; neither lets anything move through the FIFOs
  assign active = rdy_in && !roll_back;

  assign in_res[0] = '{entry: alu_entry_in, value: alu_value_in, pc: alu_pc_in};
  assign in_res[1] = '{entry: lsb_entry_in, value: lsb_value_in, pc: 32'h0};
  assign req       = {lsb_valid_in, alu_valid_in};

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign ready[i]    = (count[i] < DEPTH_C) && rdy_in;
      assign push[i]     = req[i] && ready[i] && active;
      assign nonempty[i] = (count[i] != '0);
`ifdef CDB_BYPASS_EN
      // an empty FIFO presents the incoming push as its head
      assign cand[i]      = nonempty[i] || push[i];
      assign sel_res[i]   = nonempty[i] ? head_res[i] : in_res[i];
      assign fifo_push[i] = push[i] && !(gnt_vld && (gnt_src == 1'(i)) && !nonempty[i]);
`else
      assign cand[i]      = nonempty[i];
      assign sel_res[i]   = head_res[i];
      assign fifo_push[i] = push[i];
`endif
      assign fifo_pop[i]  = gnt_vld && (gnt_src == 1'(i)) && nonempty[i];

      cdb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(res_t))) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .flush (roll_back),
        .push  (fifo_push[i]),
        .pop   (fifo_pop[i]),
        .din   (in_res[i]),
        .head  (head_res[i]),
        .count (count[i])
      );
    end
  endgenerate

  assign alu_ready_out = ready[0];
  assign lsb_ready_out = ready[1];

  // tie goes to whichever source did not win the previous grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = 1'b0;
    if (active) begin
      if (&cand) begin
        gnt_vld = 1'b1;
        gnt_src = ~last_grant;
      end else if (cand[0]) begin
        gnt_vld = 1'b1;
        gnt_src = 1'b0;
      end else if (cand[1]) begin
        gnt_vld = 1'b1;
        gnt_src = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid_out <= 1'b0;
      cdb_src_out   <= 1'b0;
      cdb_entry_out <= '0;
      cdb_value_out <= '0;
      cdb_pc_out    <= '0;
      last_grant    <= 1'b1;
    end else if (roll_back) begin
      cdb_valid_out <= 1'b0;
    end else if (rdy_in) begin
      cdb_valid_out <= gnt_vld;
      if (gnt_vld) begin
        cdb_src_out   <= gnt_src;
        cdb_entry_out <= sel_res[gnt_src].entry;
        cdb_value_out <= sel_res[gnt_src].value;
        cdb_pc_out    <= sel_res[gnt_src].pc;
        last_grant    <= gnt_src;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter (default build, FIFO_DEPTH=4, ENTRY_W=6).
module tb_cdb_arbiter;
  localparam int EW = 6;

  logic          clk_in = 1'b0, rst_n_in = 1'b1, rdy_in = 1'b1, roll_back = 1'b0;
  logic          alu_valid_in = 1'b0, lsb_valid_in = 1'b0;
  logic [EW-1:0] alu_entry_in = '0, lsb_entry_in = '0;
  logic [31:0]   alu_value_in = '0, alu_pc_in = '0, lsb_value_in = '0;
  logic          alu_ready_out, lsb_ready_out, cdb_valid_out, cdb_src_out;
  logic [EW-1:0] cdb_entry_out;
  logic [31:0]   cdb_value_out, cdb_pc_out;

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter #(.FIFO_DEPTH(4), .ENTRY_W(EW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .alu_valid_in(alu_valid_in), .alu_entry_in(alu_entry_in), .alu_value_in(alu_value_in),
    .alu_pc_in(alu_pc_in), .alu_ready_out(alu_ready_out),
    .lsb_valid_in(lsb_valid_in), .lsb_entry_in(lsb_entry_in), .lsb_value_in(lsb_value_in),
    .lsb_ready_out(lsb_ready_out),
    .cdb_valid_out(cdb_valid_out), .cdb_src_out(cdb_src_out), .cdb_entry_out(cdb_entry_out),
    .cdb_value_out(cdb_value_out), .cdb_pc_out(cdb_pc_out)
  );

  always #5 clk_in = ~clk_in;

  // payloads are derived from the tag so every broadcast is fully predictable
  function automatic logic [31:0] exp_val(bit src, int t);
    return src ? 32'hB000_0000 + 32'(t) : 32'hA000_0000 + 32'(t);
  endfunction
  function automatic logic [31:0] exp_pc(bit src, int t);
    return src ? 32'h0 : 32'h1000 + 32'(t) * 4;
  endfunction

  task automatic step(input bit av, input int at, input bit lv, input int lt);
    alu_valid_in = av; alu_entry_in = EW'(at);
    alu_value_in = exp_val(1'b0, at); alu_pc_in = exp_pc(1'b0, at);
    lsb_valid_in = lv; lsb_entry_in = EW'(lt); lsb_value_in = exp_val(1'b1, lt);
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    alu_valid_in = 0; lsb_valid_in = 0; rdy_in = 1; roll_back = 0;
    #2 rst_n_in = 0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_n_in = 1;
  endtask

  task automatic test_reset();
    #3 rst_n_in = 0;
    #1;
    n_vec++;
    if ({cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out} !== '0 ||
        alu_ready_out !== 1'b1 || lsb_ready_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b src=%b tag=%0d val=%h pc=%h ardy=%b lrdy=%b, want all 0 and ready 1",
               cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out, alu_ready_out, lsb_ready_out);
    end
    rdy_in = 0; #1;
    n_vec++;
    if (alu_ready_out !== 1'b0 || lsb_ready_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_follows_rdy: got ardy=%b lrdy=%b, want 0 0", alu_ready_out, lsb_ready_out);
    end
    rdy_in = 1;
    @(posedge clk_in); #1;
    rst_n_in = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      n_vec++;
      if (cdb_valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL idle_valid cyc%0d: got %b want 0", i, cdb_valid_out);
      end
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    alu_valid_in = 1; alu_entry_in = 5; alu_value_in = 32'h1234; alu_pc_in = 32'h100;
    @(posedge clk_in); #1;
    alu_valid_in = 0;
    n_vec++;
    if (cdb_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency: got valid=%b after push edge, want 0", cdb_valid_out);
    end
    @(posedge clk_in); #1;
    n_vec++;
    if ({cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out} !==
        {1'b1, 1'b0, 6'd5, 32'h1234, 32'h100}) begin
      n_err++;
      $display("FAIL single_bcast: got v=%b src=%b tag=%0d val=%h pc=%h, want 1 0 5 00001234 00000100",
               cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out);
    end
    @(posedge clk_in); #1;
    n_vec++;
    if (cdb_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL single_oneshot: got valid=%b want 0", cdb_valid_out);
    end
  endtask

  task automatic test_contention();
    int at[8] = '{1, 2, 3, 0, 0, 0, 0, 0};
    int lt[8] = '{9, 10, 11, 0, 0, 0, 0, 0};
    bit ev[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    bit es[8] = '{0, 0, 1, 0, 1, 0, 1, 0};
    int et[8] = '{0, 1, 9, 2, 10, 3, 11, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(at[i] != 0, at[i], lt[i] != 0, lt[i]);
      n_vec++;
      if (cdb_valid_out !== ev[i] || (ev[i] &&
          {cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out} !==
          {es[i], EW'(et[i]), exp_val(es[i], et[i]), exp_pc(es[i], et[i])})) begin
        n_err++;
        $display("FAIL contention cyc%0d: got v=%b src=%b tag=%0d val=%h pc=%h, want v=%b src=%b tag=%0d",
                 i, cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out, ev[i], es[i], et[i]);
      end
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    // both sources push every cycle; LSB fills at edge 6 and its 7th push (tag 26) is dropped
    for (int i = 0; i < 14; i++) begin
      bit ev, es;
      int et;
      step(i < 6, i < 6 ? i + 1 : 0, i < 7, i < 7 ? 20 + i : 0);
      ev = (i >= 1 && i <= 12);
      es = (i % 2 == 0);
      et = es ? 19 + i / 2 : (i + 1) / 2;
      n_vec++;
      if (cdb_valid_out !== ev || (ev &&
          {cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out} !==
          {es, EW'(et), exp_val(es, et), exp_pc(es, et)})) begin
        n_err++;
        $display("FAIL full_order cyc%0d: got v=%b src=%b tag=%0d val=%h pc=%h, want v=%b src=%b tag=%0d",
                 i, cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out, ev, es, et);
      end
      if (i == 5) begin
        n_vec++;
        if (lsb_ready_out !== 1'b0 || alu_ready_out !== 1'b1) begin
          n_err++;
          $display("FAIL full_ready: got lrdy=%b ardy=%b, want 0 1", lsb_ready_out, alu_ready_out);
        end
      end
      if (i == 6) begin
        n_vec++;
        if (lsb_ready_out !== 1'b1) begin
          n_err++;
          $display("FAIL full_ready_after_pop: got lrdy=%b want 1", lsb_ready_out);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      bit ev;
      step(0, 0, i < 6, 30 + i);
      ev = (i >= 1 && i <= 6);
      n_vec++;
      if (cdb_valid_out !== ev || (ev &&
          {cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out} !==
          {1'b1, EW'(29 + i), exp_val(1'b1, 29 + i), 32'h0})) begin
        n_err++;
        $display("FAIL wrap_order cyc%0d: got v=%b src=%b tag=%0d val=%h pc=%h, want v=%b src=1 tag=%0d",
                 i, cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out, ev, 29 + i);
      end
    end
  endtask

  task automatic test_roll_back();
    int at[11] = '{1, 2, 3, 4, 7, 0, 0, 20, 0, 0, 0};
    int lt[11] = '{9, 10, 0, 0, 15, 0, 0, 21, 0, 0, 0};
    bit ev[11] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0};
    bit es[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    int et[11] = '{0, 1, 9, 2, 0, 0, 0, 0, 21, 20, 0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      // edge 5 flushes with rdy_in low as well; last_grant (ALU) must survive
      roll_back = (i == 4);
      rdy_in    = (i != 4);
      step(at[i] != 0, at[i], lt[i] != 0, lt[i]);
      roll_back = 0;
      rdy_in    = 1;
      n_vec++;
      if (cdb_valid_out !== ev[i] || (ev[i] &&
          {cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out} !==
          {es[i], EW'(et[i]), exp_val(es[i], et[i]), exp_pc(es[i], et[i])})) begin
        n_err++;
        $display("FAIL roll_back cyc%0d: got v=%b src=%b tag=%0d val=%h pc=%h, want v=%b src=%b tag=%0d",
                 i, cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out, ev[i], es[i], et[i]);
      end
    end
  endtask

  task automatic test_pause();
    bit es[4] = '{1, 0, 1, 0};
    int et[4] = '{9, 2, 10, 0};
    do_reset();
    step(1, 1, 1, 9);
    step(1, 2, 1, 10);
    rdy_in = 0; alu_valid_in = 1; alu_entry_in = 50; lsb_valid_in = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) #1;
      else begin @(posedge clk_in); #1; end
      n_vec++;
      if ({cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out,
           alu_ready_out, lsb_ready_out} !==
          {1'b1, 1'b0, EW'(1), exp_val(1'b0, 1), exp_pc(1'b0, 1), 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL pause_hold cyc%0d: got v=%b src=%b tag=%0d ardy=%b lrdy=%b, want v=1 src=0 tag=1 rdy 0 0",
                 k, cdb_valid_out, cdb_src_out, cdb_entry_out, alu_ready_out, lsb_ready_out);
      end
    end
    rdy_in = 1;
    for (int i = 0; i < 4; i++) begin
      bit ev;
      step(0, 0, 0, 0);
      ev = (i < 3);
      n_vec++;
      if (cdb_valid_out !== ev || (ev &&
          {cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out} !==
          {es[i], EW'(et[i]), exp_val(es[i], et[i]), exp_pc(es[i], et[i])})) begin
        n_err++;
        $display("FAIL pause_resume cyc%0d: got v=%b src=%b tag=%0d, want v=%b src=%b tag=%0d",
                 i, cdb_valid_out, cdb_src_out, cdb_entry_out, ev, es[i], et[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 5, 1, 6);
    step(0, 0, 0, 0);
    #3 rst_n_in = 0;
    #1;
    n_vec++;
    if ({cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b src=%b tag=%0d val=%h pc=%h, want all 0",
               cdb_valid_out, cdb_src_out, cdb_entry_out, cdb_value_out, cdb_pc_out);
    end
    @(posedge clk_in); #1;
    rst_n_in = 1;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0);
      n_vec++;
      if (cdb_valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL async_reset_flush cyc%0d: got valid=%b tag=%0d, want 0", i, cdb_valid_out, cdb_entry_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_full_wrap();
    test_roll_back();
    test_pause();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
